// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction fetch stage: FSM states, PCSrc selects,
// fault causes and the NOP word presented before the first fetch completes.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_JALR   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUSERR   = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Combinational next-PC selection plus word-alignment check; kept separate so a
// later pipelined front end can reuse it unchanged.
module instr_fetch_pc_next_sel
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pc_target_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    case (pcsrc_i)
      PCSRC_TARGET: next_pc_o = pc_target_i;
      // jalr clears bit 0 of rs1+imm; bit 1 may still leave the target misaligned
      PCSRC_JALR:   next_pc_o = alu_result_i & ~32'd1;
      default:      next_pc_o = pc_i + 32'd4;
    endcase
    misaligned_o = is_misaligned(next_pc_o);
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, fetches over a req/gnt/rvalid bus with wait
// states, holds each instruction for one execute slot and traps fetch faults.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  input  logic        stall_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic         fault_q;
  logic [1:0]   cause_q;
  logic [7:0]   tmo_cnt_q;

  logic [31:0]  next_pc_d;
  logic         next_misaligned_d;

  instr_fetch_pc_next_sel u_pc_next_sel (
    .pc_i         (pc_q),
    .pcsrc_i      (PCSrc),
    .pc_target_i  (pc_target),
    .alu_result_i (alu_result),
    .next_pc_o    (next_pc_d),
    .misaligned_o (next_misaligned_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= CAUSE_NONE;
      tmo_cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;

        ST_REQ: begin
          if (imem_gnt) begin
            tmo_cnt_q <= '0;
            state_q   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
          // data arriving on the last permitted cycle takes priority over the timeout
          if (imem_rvalid) begin
            if (imem_err) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_BUSERR;
              state_q <= ST_FAULT;
            end else begin
              instr_q       <= imem_rdata;
              instr_valid_q <= 1'b1;
              state_q       <= ST_EXEC;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            state_q <= ST_FAULT;
          end
        end

        ST_EXEC: begin
          if (!stall_i) begin
            pc_q          <= next_pc_d;
            instr_valid_q <= 1'b0;
            if (next_misaligned_d) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
              state_q <= ST_FAULT;
            end else begin
              state_q <= ST_REQ;
            end
          end
        end

        ST_FAULT: state_q <= ST_FAULT;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch
// traffic compared against a PC/memory reference model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        stall_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;
  logic [1:0]  r_src;
  logic [31:0] r_tgt;
  logic [31:0] r_alu;
  int unsigned r_stall;

  instr_fetch #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .pc_target   (pc_target),
    .alu_result  (alu_result),
    .stall_i     (stall_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // Instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                           input logic [31:0] tgt, input logic [31:0] alu);
    case (src)
      2'd1:    return tgt;
      2'd2:    return alu - (alu % 2);
      default: return cur + 32'd4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", imem_req, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_cause", fault_cause, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_vals();
    rst_n = 1'b1;
    m_pc  = RST_PC;
  endtask

  task automatic serve(input int gdly, input int rdly, input bit err, input bit stray);
    wait_req();
    chk("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < gdly; i++) begin
      imem_gnt    = 1'b0;
      imem_rvalid = stray;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      chk("req_held", imem_req, 1);
      chk("addr_held", imem_addr, m_pc);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("req_drop", imem_req, 0);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("wait_no_valid", instr_valid, 0);
      chk("wait_no_fault", fetch_fault, 0);
    end
    imem_rvalid = 1'b1;
    imem_err    = err;
    imem_rdata  = mem_word(m_pc);
    step();
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic check_exec();
    chk("exec_valid", instr_valid, 1);
    chk("exec_instr", instr, mem_word(m_pc));
    chk("exec_pc", pc, m_pc);
    chk("exec_pc4", pc_plus4, m_pc + 32'd4);
    chk("exec_nofault", fetch_fault, 0);
    chk("exec_noreq", imem_req, 0);
  endtask

  task automatic advance(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    PCSrc      = src;
    pc_target  = tgt;
    alu_result = alu;
    step();
    m_pc = ref_next(m_pc, src, tgt, alu);
    chk("pc_update", pc, m_pc);
    chk("valid_drop", instr_valid, 0);
    if (m_pc % 4 != 0) begin
      chk("mis_fault", fetch_fault, 1);
      chk("mis_cause", fault_cause, 2'b01);
      chk("mis_noreq", imem_req, 0);
    end else begin
      chk("adv_nofault", fetch_fault, 0);
      chk("next_req", imem_req, 1);
    end
    PCSrc = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 2'b00; pc_target = '0; alu_result = '0; stall_i = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    m_pc = RST_PC;
    step();

    // Reset release with zero-wait memory, then 3-cycle cadence
    do_reset();
    step();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, RST_PC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("c2_valid", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(m_pc);
    step();
    imem_rvalid = 1'b0;
    check_exec();
    for (int k = 0; k < 3; k++) begin
      advance(2'b00, '0, '0);
      serve(0, 0, 1'b0, 1'b0);
      check_exec();
    end

    // Wait states with stray rvalid during REQ
    advance(2'b00, '0, '0);
    serve(5, 3, 1'b0, 1'b1);
    check_exec();
    advance(2'b00, '0, '0);

    // Control transfers and wrap-around
    serve(0, 0, 1'b0, 1'b0);
    check_exec();
    advance(2'b01, 32'h0000_0100, '0);
    serve(1, 1, 1'b0, 1'b0);
    check_exec();
    advance(2'b10, '0, 32'h0000_0205);
    chk("jalr_addr", imem_addr, 32'h0000_0204);
    serve(0, 2, 1'b0, 1'b0);
    check_exec();
    advance(2'b01, 32'hFFFF_FFFC, '0);
    serve(0, 0, 1'b0, 1'b0);
    check_exec();
    advance(2'b00, '0, '0);
    chk("wrap_pc", pc, 32'h0000_0000);
    serve(0, 0, 1'b0, 1'b0);
    check_exec();

    // Stall holds the execute slot
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCSrc = 2'b01; pc_target = 32'h0000_0888;
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", pc, m_pc);
      chk("stall_noreq", imem_req, 0);
    end
    stall_i = 1'b0;
    advance(2'b00, '0, '0);
    serve(0, 0, 1'b0, 1'b0);
    check_exec();

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      r_stall = $urandom_range(0, 2);
      if (r_stall > 0) begin
        stall_i = 1'b1;
        repeat (r_stall) begin
          step();
          chk("rnd_stall_valid", instr_valid, 1);
          chk("rnd_stall_pc", pc, m_pc);
        end
        stall_i = 1'b0;
      end
      r_src = 2'($urandom_range(0, 3));
      r_tgt = $urandom() & 32'hFFFF_FFFC;
      r_alu = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      advance(r_src, r_tgt, r_alu);
      serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
      check_exec();
    end

    // Misaligned target traps and stays trapped
    advance(2'b01, 32'h0000_0102, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fault_sticky", fetch_fault, 1);
      chk("fault_cause_hold", fault_cause, 2'b01);
      chk("fault_pc", pc, 32'h0000_0102);
      chk("fault_noreq", imem_req, 0);
      chk("fault_novalid", instr_valid, 0);
    end

    // Bus error
    do_reset();
    serve(0, 1, 1'b1, 1'b0);
    chk("buserr_fault", fetch_fault, 1);
    chk("buserr_cause", fault_cause, 2'b10);
    chk("buserr_pc", pc, RST_PC);
    chk("buserr_valid", instr_valid, 0);
    step();
    chk("buserr_noreq", imem_req, 0);

    // Timeout after 4 WAIT cycles
    do_reset();
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_early", fetch_fault, 0);
    end
    step();
    chk("tmo_fault", fetch_fault, 1);
    chk("tmo_cause", fault_cause, 2'b11);
    chk("tmo_noreq", imem_req, 0);
    chk("tmo_valid", instr_valid, 0);

    // rvalid on the 4th WAIT cycle beats the timeout
    do_reset();
    serve(0, 3, 1'b0, 1'b0);
    check_exec();

    // Reset during WAIT with a late rvalid
    advance(2'b00, '0, '0);
    wait_req();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    rst_n       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    chk_reset_vals();
    rst_n = 1'b1;
    m_pc  = RST_PC;
    step();
    chk("late_rv_valid", instr_valid, 0);
    chk("late_rv_instr", instr, NOP);
    imem_rvalid = 1'b0;
    serve(0, 0, 1'b0, 1'b0);
    check_exec();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
